// File: rtl/seg7_display_ctrl_pkg.sv
// rtl/seg7_display_ctrl_pkg.sv - shared types and segment constants for seg7_display_ctrl
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_UPDATE = 2'd2
    } state_e;

    localparam int MAX_DIGITS = 8;

    // Segment order g..a, active-high
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - load handshake and display outputs of seg7_display_ctrl
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 5,
    parameter int DATA_W     = 16
);
    logic                    load;
    logic [DATA_W-1:0]       value;
    logic                    mode;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] seg_out;

    modport master (
        output load, value, mode, blank_lz, blink_mask,
        input  busy, done, overflow, seg_out
    );

    modport slave (
        input  load, value, mode, blank_lz, blink_mask,
        output busy, done, overflow, seg_out
    );
endinterface

// File: rtl/seg7_display_ctrl_decoder.sv
// rtl/seg7_display_ctrl_decoder.sv - 4-bit digit to active-high seven-segment pattern
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX_SEG[digit_i];
endmodule

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit seven-segment controller with double-dabble and blink
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 5,
    parameter int DATA_W         = 16,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    seg7_display_ctrl_if.slave bus
);
    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SEG_W  = 7 * NUM_DIGITS;
    localparam int EXT_W  = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam int BCNT_W = $clog2(BLINK_DIV);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic                ovf_sticky_q, ovf_sticky_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                mode_q, mode_d, blank_q, blank_d;
    logic [SEG_W-1:0]    disp_q, disp_d, disp_new, seg_q, seg_d;
    logic                ovf_q, ovf_d, done_q, done_d;
    logic [BCNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [EXT_W-1:0]    ext;
    logic                ovf_new, lead_zero;
    logic [NUM_DIGITS-1:0][3:0] digit_sel;
    logic [NUM_DIGITS-1:0][6:0] dec_seg;

    // Hex mode keeps the captured value unshifted in bin_q
    assign ext     = EXT_W'(bin_q);
    assign ovf_new = mode_q ? ((ext >> BCD_W) != '0) : ovf_sticky_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_sel[i] = mode_q ? ext[4*i +: 4] : bcd_q[4*i +: 4];
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (.digit_i(digit_sel[g]), .seg_o(dec_seg[g]));
    end

    always_comb begin
        disp_new  = '0;
        lead_zero = blank_q;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (digit_sel[i] == 4'd0) && (i != 0);
            if (ovf_new)        disp_new[7*i +: 7] = SEG_DASH;
            else if (lead_zero) disp_new[7*i +: 7] = SEG_BLANK;
            else                disp_new[7*i +: 7] = dec_seg[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        ovf_sticky_d = ovf_sticky_q;
        iter_d       = iter_q;
        mode_d       = mode_q;
        blank_d      = blank_q;
        disp_d       = disp_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    bin_d        = bus.value;
                    mode_d       = bus.mode;
                    blank_d      = bus.blank_lz;
                    bcd_d        = '0;
                    ovf_sticky_d = 1'b0;
                    iter_d       = ITER_W'(DATA_W);
                    state_d      = bus.mode ? S_UPDATE : S_CONV;
                end
            end
            S_CONV: begin
                bcd_d        = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d        = bin_q << 1;
                ovf_sticky_d = ovf_sticky_q | bcd_adj[BCD_W-1];
                iter_d       = iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                disp_d  = disp_new;
                ovf_d   = ovf_new;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Blink uses disp_d so a fresh value and its blink state land together
    always_comb begin
        blink_cnt_d = blink_cnt_q + BCNT_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BCNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        seg_d = disp_d;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (phase_q && bus.blink_mask[i]) seg_d[7*i +: 7] = SEG_BLANK;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            ovf_sticky_q <= 1'b0;
            iter_q       <= '0;
            mode_q       <= 1'b0;
            blank_q      <= 1'b0;
            disp_q       <= '0;
            seg_q        <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            ovf_sticky_q <= ovf_sticky_d;
            iter_q       <= iter_d;
            mode_q       <= mode_d;
            blank_q      <= blank_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.seg_out  = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;
    localparam int DW  = 16;
    localparam int DIV = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   edge_no = 0;
    int   n_rst = 0;
    bit   started = 1'b0;
    bit   m_phase = 1'b0;

    int nd_of [2] = '{5, 4};
    bit al_of [2] = '{1'b1, 1'b0};

    bit          m_busy [2];
    bit          m_done [2];
    int          m_land [2];
    logic [31:0] p_val [2];
    bit          p_hex [2];
    bit          p_blz [2];
    logic [31:0] d_val [2];
    bit          d_hex [2];
    bit          d_blz [2];
    bit          d_valid [2];
    logic [7:0]  m_mask [2];

    always #5 clk = ~clk;

    seg7_display_ctrl_if #(.NUM_DIGITS(5), .DATA_W(DW)) if_a ();
    seg7_display_ctrl_if #(.NUM_DIGITS(4), .DATA_W(DW)) if_b ();

    seg7_display_ctrl #(.NUM_DIGITS(5), .DATA_W(DW), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk_clk(clk), .reset_reset_n(rstn), .bus(if_a));
    seg7_display_ctrl #(.NUM_DIGITS(4), .DATA_W(DW), .BLINK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk_clk(clk), .reset_reset_n(rstn), .bus(if_b));

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic longint pw(longint b, int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic bit exp_ovf(int nd, logic [31:0] v, bit hex);
        return longint'({32'd0, v}) >= pw(hex ? 16 : 10, nd);
    endfunction

    function automatic logic [63:0] exp_seg(int nd, logic [31:0] v, bit hex, bit blz, bit valid,
                                            bit ph, logic [7:0] mask, bit al);
        logic [63:0] s = '0;
        logic [6:0]  g;
        longint base = hex ? 16 : 10;
        longint lv   = longint'({32'd0, v});
        for (int i = 0; i < nd; i++) begin
            if (!valid)                              g = 7'h00;
            else if (exp_ovf(nd, v, hex))            g = 7'h40;
            else if (blz && i > 0 && lv < pw(base, i)) g = 7'h00;
            else                                     g = seg_of(int'((lv / pw(base, i)) % base));
            if (ph && mask[i]) g = 7'h00;
            if (al) g = ~g;
            s[7*i +: 7] = g;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edge_no);
        end
    endtask

    task automatic model_step(input int u, input bit ld, input logic [31:0] v, input bit md,
                              input bit bz, input logic [7:0] mk);
        m_done[u] = 1'b0;
        m_mask[u] = mk;
        if (m_busy[u]) begin
            if (edge_no == m_land[u]) begin
                d_val[u]   = p_val[u];
                d_hex[u]   = p_hex[u];
                d_blz[u]   = p_blz[u];
                d_valid[u] = 1'b1;
                m_busy[u]  = 1'b0;
                m_done[u]  = 1'b1;
            end
        end else if (ld) begin
            m_busy[u] = 1'b1;
            p_val[u]  = v;
            p_hex[u]  = md;
            p_blz[u]  = bz;
            m_land[u] = edge_no + (md ? 1 : DW + 1);
        end
    endtask

    task automatic cmp_unit(input int u, input bit busy, input bit done, input bit ovf,
                            input logic [63:0] seg);
        chk($sformatf("busy_u%0d", u), 64'(busy), 64'(m_busy[u]));
        chk($sformatf("done_u%0d", u), 64'(done), 64'(m_done[u]));
        chk($sformatf("ovf_u%0d", u), 64'(ovf), 64'(d_valid[u] && exp_ovf(nd_of[u], d_val[u], d_hex[u])));
        chk($sformatf("seg_u%0d", u), seg,
            exp_seg(nd_of[u], d_val[u], d_hex[u], d_blz[u], d_valid[u], m_phase, m_mask[u], al_of[u]));
    endtask

    initial forever begin
        @(posedge clk);
        edge_no++;
        started = 1'b1;
        if (!rstn) begin
            n_rst   = 0;
            m_phase = 1'b0;
            for (int u = 0; u < 2; u++) begin
                m_busy[u] = 1'b0; m_done[u] = 1'b0; d_valid[u] = 1'b0; m_mask[u] = '0;
            end
        end else begin
            n_rst++;
            m_phase = (((n_rst - 1) / DIV) % 2) == 1;
            model_step(0, if_a.load, 32'(if_a.value), if_a.mode, if_a.blank_lz, 8'(if_a.blink_mask));
            model_step(1, if_b.load, 32'(if_b.value), if_b.mode, if_b.blank_lz, 8'(if_b.blink_mask));
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            cmp_unit(0, if_a.busy, if_a.done, if_a.overflow, 64'(if_a.seg_out));
            cmp_unit(1, if_b.busy, if_b.done, if_b.overflow, 64'(if_b.seg_out));
        end
    end

    task automatic load_u(input int u, input logic [31:0] v, input bit md, input bit bz);
        @(negedge clk);
        if (u == 0) begin
            if_a.value = 16'(v); if_a.mode = md; if_a.blank_lz = bz; if_a.load = 1'b1;
        end else begin
            if_b.value = 16'(v); if_b.mode = md; if_b.blank_lz = bz; if_b.load = 1'b1;
        end
        @(negedge clk);
        if_a.load = 1'b0;
        if_b.load = 1'b0;
    endtask

    task automatic wait_done(input int u, output int n);
        n = 0;
        while (((u == 0) ? if_a.done : if_b.done) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL done_timeout unit=%0d actual=no_done expected=done", u);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dcount;
        int lit;
        bit steady;
        logic [27:0] first;

        if_a.load = 0; if_a.value = '0; if_a.mode = 0; if_a.blank_lz = 0; if_a.blink_mask = '0;
        if_b.load = 0; if_b.value = '0; if_b.mode = 0; if_b.blank_lz = 0; if_b.blink_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg_a", 64'(if_a.seg_out), 64'h7_FFFF_FFFF);
        chk("rst_seg_b", 64'(if_b.seg_out), 64'h0);
        chk("rst_busy_a", 64'(if_a.busy), 64'h0);
        rstn = 1'b1;

        load_u(0, 1234, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midconv_busy", 64'(if_a.busy), 64'h0);
        chk("midconv_seg", 64'(if_a.seg_out), 64'h7_FFFF_FFFF);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            dcount += int'(if_a.done);
        end
        chk("midconv_no_done", 64'(dcount), 64'h0);

        load_u(0, 12345, 1'b0, 1'b0);
        wait_done(0, n);
        chk("lat_dec", 64'(n), 64'd17);
        chk("seg_12345", 64'(if_a.seg_out), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
        chk("ovf_12345", 64'(if_a.overflow), 64'h0);

        load_u(0, 42, 1'b0, 1'b1);
        wait_done(0, n);
        chk("seg_42_blz", 64'(if_a.seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));
        load_u(0, 0, 1'b0, 1'b1);
        wait_done(0, n);
        chk("seg_0_blz", 64'(if_a.seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

        load_u(1, 65535, 1'b0, 1'b0);
        wait_done(1, n);
        chk("ovf_65535", 64'(if_b.overflow), 64'h1);
        chk("seg_65535", 64'(if_b.seg_out), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
        load_u(1, 32'hBEEF, 1'b1, 1'b0);
        wait_done(1, n);
        chk("lat_hex", 64'(n), 64'd1);
        chk("seg_beef", 64'(if_b.seg_out), 64'({7'h7C, 7'h79, 7'h79, 7'h71}));
        chk("ovf_beef", 64'(if_b.overflow), 64'h0);

        load_u(0, 777, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        load_u(0, 999, 1'b0, 1'b0);
        wait_done(0, n);
        chk("seg_busy_ignore", 64'(if_a.seg_out), 64'({7'h40, 7'h40, 7'h78, 7'h78, 7'h78}));
        if_a.value = 16'd5; if_a.mode = 1'b1; if_a.blank_lz = 1'b1; if_a.load = 1'b1;
        @(negedge clk);
        if_a.load = 1'b0;
        chk("b2b_busy", 64'(if_a.busy), 64'h1);
        wait_done(0, n);
        chk("b2b_lat", 64'(n), 64'd1);
        chk("seg_5_hex", 64'(if_a.seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12}));

        if_a.blink_mask = 5'b00001;
        repeat (2) @(negedge clk);
        lit = 0;
        steady = 1'b1;
        first = if_a.seg_out[34:7];
        repeat (16) begin
            @(negedge clk);
            if (if_a.seg_out[6:0] != 7'h7F) lit++;
            if (if_a.seg_out[34:7] != first) steady = 1'b0;
        end
        chk("blink_lit_cycles", 64'(lit), 64'd8);
        chk("blink_others_steady", 64'(steady), 64'h1);
        if_a.blink_mask = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
